// File: rtl/l2_line_burst_adaptor_if.sv
// L2-side and pmem-side bus bundle for l2_line_burst_adaptor.
// The master modport is the environment (L2 controller plus memory); the slave modport is the adaptor.
interface l2_line_burst_adaptor_if #(
  parameter int s_offset = 5,
  parameter int s_beat   = 64
);
  localparam int LINE = 8 * (2 ** s_offset);

  logic [31:0]       mem_address;
  logic              mem_read;
  logic              mem_write;
  logic [LINE-1:0]   line_i;
  logic [LINE-1:0]   line_o;
  logic              mem_resp;
  logic [31:0]       pmem_address;
  logic              pmem_read;
  logic              pmem_write;
  logic [s_beat-1:0] pmem_rdata;
  logic [s_beat-1:0] pmem_wdata;
  logic              pmem_resp;

  modport master (
    output mem_address, mem_read, mem_write, line_i, pmem_rdata, pmem_resp,
    input  line_o, mem_resp, pmem_address, pmem_read, pmem_write, pmem_wdata
  );

  modport slave (
    input  mem_address, mem_read, mem_write, line_i, pmem_rdata, pmem_resp,
    output line_o, mem_resp, pmem_address, pmem_read, pmem_write, pmem_wdata
  );
endinterface

// File: rtl/l2_line_burst_adaptor.sv
// Line <-> beat burst adaptor between the L2 data array and pmem; one transaction at a time.
// Define L2_ADAPTOR_EARLY_RESP_EN to return mem_resp in the same cycle as the final beat.
module l2_line_burst_adaptor #(
  parameter int s_offset = 5,
  parameter int s_beat   = 64
) (
  input logic                     clk,
  input logic                     rst,
  l2_line_burst_adaptor_if.slave  bus
);
  localparam int LINE    = 8 * (2 ** s_offset);
  localparam int N_BEATS = LINE / s_beat;
  localparam int CW      = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
  localparam logic [CW-1:0] LAST = CW'(N_BEATS - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] RBURST = 3'd1;
  localparam logic [2:0] RDONE  = 3'd2;
  localparam logic [2:0] WBURST = 3'd3;
  localparam logic [2:0] WDONE  = 3'd4;

  logic [2:0]      state;
  logic [LINE-1:0] line_buf;
  logic [31:0]     addr;
  logic [CW-1:0]   cnt;
  logic            last_beat;
  logic [31:0]     aligned;

  assign aligned   = bus.mem_address & ~((32'd1 << s_offset) - 32'd1);
  assign last_beat = bus.pmem_resp && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      line_buf <= '0;
      addr     <= '0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Write wins when both requests are up.
          if (bus.mem_write) begin
            line_buf <= bus.line_i;
            addr     <= aligned;
            state    <= WBURST;
          end else if (bus.mem_read) begin
            addr     <= aligned;
            state    <= RBURST;
          end
        end
        RBURST: begin
          if (bus.pmem_resp) begin
            line_buf[s_beat*int'(cnt) +: s_beat] <= bus.pmem_rdata;
            if (cnt == LAST) begin
              cnt <= '0;
`ifdef L2_ADAPTOR_EARLY_RESP_EN
              state <= IDLE;
`else
              state <= RDONE;
`endif
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        WBURST: begin
          if (bus.pmem_resp) begin
            if (cnt == LAST) begin
              cnt <= '0;
`ifdef L2_ADAPTOR_EARLY_RESP_EN
              state <= IDLE;
`else
              state <= WDONE;
`endif
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        RDONE, WDONE: state <= IDLE;
        default:      state <= IDLE;
      endcase
    end
  end

  assign bus.pmem_read    = (state == RBURST);
  assign bus.pmem_write   = (state == WBURST);
  assign bus.pmem_address = addr;
  assign bus.pmem_wdata   = line_buf[s_beat*int'(cnt) +: s_beat];

  always_comb begin
    bus.mem_resp = (state == RDONE) || (state == WDONE);
    bus.line_o   = line_buf;
`ifdef L2_ADAPTOR_EARLY_RESP_EN
    if ((state == RBURST || state == WBURST) && last_beat)
      bus.mem_resp = 1'b1;
    // Final fill beat bypasses the buffer so the line is complete this cycle.
    if (state == RBURST && last_beat)
      bus.line_o[LINE-s_beat +: s_beat] = bus.pmem_rdata;
`endif
  end
endmodule
